// File: rtl/rs232_transmit.sv
// rs232_transmit: valid/ready byte-wide UART transmitter (8N1, LSB first) with host RTS flow control.
// Define RS232_TX_PARITY_EN to build 8E1 frames (even parity bit after data bit 7).
module rs232_transmit #(
    parameter int unsigned CLOCK_FREQ = 133000000,
    parameter int unsigned BAUD_RATE  = 12000000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    input  logic       rs232_rtsn,
    output logic       rs232_rxd,
    output logic       busy
);

`ifdef RS232_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    localparam logic [32:0] BAUD_STEP  = 33'(BAUD_RATE);
    localparam logic [32:0] CLOCK_WRAP = 33'(CLOCK_FREQ);

    state_t      state_reg, state_next;
    logic [1:0]  rts_sync_reg;
    logic [7:0]  shift_reg, shift_next;
    logic [2:0]  count_reg, count_next;
    logic [31:0] acc_reg, acc_next;
    logic        line_reg, line_next;
    logic        ready_reg, ready_next;
    logic        busy_reg, busy_next;
`ifdef RS232_TX_PARITY_EN
    logic        parity_reg, parity_next;
`endif

    logic        rts_ok;
    logic        accept;
    logic [32:0] acc_sum;
    logic        bit_done;

    // Two-flop synchroniser; resets to "host not ready".
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rts_sync_reg <= 2'b11;
        end else begin
            rts_sync_reg <= {rts_sync_reg[0], rs232_rtsn};
        end
    end

    assign rts_ok = ~rts_sync_reg[1];
    assign accept = valid && ready_reg;

    // Fractional divider: the remainder carries over, so bit edges never drift.
    assign acc_sum  = {1'b0, acc_reg} + BAUD_STEP;
    assign bit_done = (state_reg != IDLE) && (acc_sum >= CLOCK_WRAP);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg  <= IDLE;
            shift_reg  <= 8'h00;
            count_reg  <= 3'd0;
            acc_reg    <= 32'd0;
            line_reg   <= 1'b1;
            ready_reg  <= 1'b0;
            busy_reg   <= 1'b0;
`ifdef RS232_TX_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            shift_reg  <= shift_next;
            count_reg  <= count_next;
            acc_reg    <= acc_next;
            line_reg   <= line_next;
            ready_reg  <= ready_next;
            busy_reg   <= busy_next;
`ifdef RS232_TX_PARITY_EN
            parity_reg <= parity_next;
`endif
        end
    end

    always_comb begin
        state_next  = state_reg;
        shift_next  = shift_reg;
        count_next  = count_reg;
        acc_next    = acc_reg;
`ifdef RS232_TX_PARITY_EN
        parity_next = parity_reg;
`endif

        if (state_reg != IDLE) begin
            acc_next = bit_done ? 32'(acc_sum - CLOCK_WRAP) : acc_sum[31:0];
        end

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next  = START;
                    shift_next  = data;
                    count_next  = 3'd0;
                    acc_next    = 32'd0;
`ifdef RS232_TX_PARITY_EN
                    parity_next = ^data;
`endif
                end
            end
            START: begin
                if (bit_done) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    shift_next = shift_reg >> 1;
                    count_next = count_reg + 3'd1;
                    if (count_reg == 3'd7) begin
`ifdef RS232_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef RS232_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Outputs are registered, so derive them from the state being entered.
        line_next = 1'b1;
        case (state_next)
            START:   line_next = 1'b0;
            DATA:    line_next = shift_next[0];
`ifdef RS232_TX_PARITY_EN
            PARITY:  line_next = parity_next;
`endif
            default: line_next = 1'b1;
        endcase

        ready_next = (state_next == IDLE) && rts_ok;
        busy_next  = (state_next != IDLE);
    end

    assign rs232_rxd = line_reg;
    assign ready     = ready_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_rs232_transmit.sv
// tb_rs232_transmit: scoreboard bench; a line monitor decodes frames and checks them against queued bytes.
module tb_rs232_transmit;

    localparam int BIT_CYC = 16;
`ifdef RS232_TX_PARITY_EN
    localparam int NBITS      = 11;
    localparam int STOP_IDX   = 10;
    localparam int FAST_W     = 2;
    localparam int FAST_TOTAL = 122;
`else
    localparam int NBITS      = 10;
    localparam int STOP_IDX   = 9;
    localparam int FAST_W     = 1;
    localparam int FAST_TOTAL = 111;
`endif
    localparam int FRAME_CYC = BIT_CYC * NBITS;

    typedef struct packed {
        logic [7:0] d;
        logic       p;
    } exp_t;

    logic       clk    = 1'b0;
    logic       resetn = 1'b1;
    logic [7:0] data   = 8'h00;
    logic       valid  = 1'b0;
    logic       rtsn   = 1'b0;
    logic       ready, rxd, busy;

    logic [7:0] f_data  = 8'h00;
    logic       f_valid = 1'b0;
    logic       f_rtsn  = 1'b0;
    logic       f_ready, f_rxd, f_busy;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   frames_seen = 0;
    int   last_hi_run = 0;
    exp_t exp_q[$];
    int   mon_start[$];

    always #5 clk = ~clk;

    rs232_transmit #(.CLOCK_FREQ(16), .BAUD_RATE(1)) dut (
        .clock(clk), .resetn(resetn), .data(data), .valid(valid), .ready(ready),
        .rs232_rtsn(rtsn), .rs232_rxd(rxd), .busy(busy)
    );

    rs232_transmit dut_fast (
        .clock(clk), .resetn(resetn), .data(f_data), .valid(f_valid), .ready(f_ready),
        .rs232_rtsn(f_rtsn), .rs232_rxd(f_rxd), .busy(f_busy)
    );

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] b, input logic p);
        exp_t e;
        e.d = b;
        e.p = p;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 400) begin
            tick();
            n++;
        end
        check(name, busy, 0);
    endtask

    // Waits for ready with valid held; returns the cycle count right after the accepting edge.
    task automatic offer(input logic [7:0] b, input logic p, output int acc_cyc);
        int n = 0;
        data  = b;
        valid = 1'b1;
        while (!ready && n < 400) begin
            tick();
            n++;
        end
        check("accept_wait", ready, 1);
        push_exp(b, p);
        tick();
        acc_cyc = cyc;
    endtask

    // Line monitor: samples each bit mid-period and scores a frame at its stop bit.
    initial begin : monitor
        bit         in_frame = 1'b0;
        int         pos = 0;
        int         hi_run = 0;
        int         k;
        logic [7:0] rx_byte = 8'h00;
`ifdef RS232_TX_PARITY_EN
        logic       rx_par = 1'b0;
`endif
        exp_t       e;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                in_frame = 1'b0;
                hi_run   = 0;
            end else begin
                if (!in_frame && !rxd) begin
                    in_frame    = 1'b1;
                    pos         = 0;
                    last_hi_run = hi_run;
                    mon_start.push_back(cyc);
                end else if (in_frame) begin
                    pos++;
                    if (pos % BIT_CYC == BIT_CYC / 2) begin
                        k = pos / BIT_CYC;
                        if (k == 0) begin
                            check("start_bit", rxd, 0);
                        end else if (k <= 8) begin
                            rx_byte[k-1] = rxd;
`ifdef RS232_TX_PARITY_EN
                        end else if (k < STOP_IDX) begin
                            rx_par = rxd;
`endif
                        end else begin
                            check("stop_bit", rxd, 1);
                            if (exp_q.size() == 0) begin
                                check("unexpected_frame", 1, 0);
                            end else begin
                                e = exp_q.pop_front();
                                check("frame_data", rx_byte, e.d);
`ifdef RS232_TX_PARITY_EN
                                check("parity_bit", rx_par, e.p);
`endif
                            end
                            frames_seen++;
                            $display("frame %0d: byte 0x%02h started at cycle %0d",
                                     frames_seen, rx_byte, mon_start[mon_start.size()-1]);
                            in_frame = 1'b0;
                        end
                    end
                end
                hi_run = rxd ? hi_run + 1 : 0;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "simulation time limit");
    end

    initial begin : stimulus
        int   k, a0, a1, a2, nb, viol, fn, ntr, fend;
        int   t[10];
        logic prev;

        #2 resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rxd", rxd, 1);
        check("reset_ready", ready, 0);
        check("reset_busy", busy, 0);
        resetn = 1'b1;
        k = 0;
        while (!ready && k < 20) begin
            tick();
            k++;
        end
        check("rts_to_ready_edges", k, 3);

        // 0xA5: full frame, busy length
        offer(8'hA5, 1'b0, a0);
        valid = 1'b0;
        check("ready_after_accept", ready, 0);
        check("busy_after_accept", busy, 1);
        check("rxd_after_accept", rxd, 0);
        nb = 0;
        while (busy && nb < 400) begin
            nb++;
            tick();
        end
        check("busy_cycles", nb, FRAME_CYC);

        // back-to-back with valid held
        offer(8'h00, 1'b0, a1);
        data = 8'hFF;
        offer(8'hFF, 1'b0, a2);
        valid = 1'b0;
        tick();
        check("b2b_accept_gap", a2 - a1, FRAME_CYC + 1);
        check("b2b_line_start_gap", mon_start[mon_start.size()-1] - mon_start[mon_start.size()-2], FRAME_CYC + 1);
        check("b2b_line_start_cycle", mon_start[mon_start.size()-1], a2);
        check("b2b_stop_high", last_hi_run, BIT_CYC + 1);
        wait_idle("idle_after_b2b");

        // host flow control blocks acceptance in IDLE
        rtsn = 1'b1;
        repeat (4) tick();
        check("ready_blocked_rts", ready, 0);
        data  = 8'h5A;
        valid = 1'b1;
        viol  = 0;
        repeat (20) begin
            tick();
            if (ready || !rxd || busy) viol++;
        end
        check("hold_off_violations", viol, 0);
        push_exp(8'h5A, 1'b0);
        rtsn = 1'b0;
        k = 0;
        while (rxd && k < 20) begin
            tick();
            k++;
        end
        check("rts_to_start_edges", k, 4);
        valid = 1'b0;
        wait_idle("idle_after_rts");

        // RTS raised during data bit 3: frame completes, then no acceptance
        offer(8'hC3, 1'b0, a0);
        valid = 1'b0;
        repeat (BIT_CYC * 4 + 5) tick();
        rtsn = 1'b1;
        wait_idle("idle_after_rts_mid");
        check("ready_after_rts_mid", ready, 0);
        data  = 8'h77;
        valid = 1'b1;
        viol  = 0;
        repeat (20) begin
            tick();
            if (ready || !rxd || busy) viol++;
        end
        check("no_accept_after_rts_mid", viol, 0);
        valid = 1'b0;
        rtsn  = 1'b0;
        repeat (4) tick();
        check("ready_restored", ready, 1);

        // reset during data bit 5 (bit 5 of 0x96 is 0)
        offer(8'h96, 1'b0, a0);
        valid = 1'b0;
        repeat (100) tick();
        check("rxd_in_bit5", rxd, 0);
        resetn = 1'b0;
        #1;
        check("reset_mid_rxd", rxd, 1);
        check("reset_mid_busy", busy, 0);
        check("reset_mid_ready", ready, 0);
        void'(exp_q.pop_back());
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        offer(8'h3C, 1'b0, a0);
        valid = 1'b0;
        wait_idle("idle_after_3c");

        // parity vectors: 0x07 odd weight, 0x03 even weight
        offer(8'h07, 1'b1, a0);
        valid = 1'b0;
        nb = 0;
        while (busy && nb < 400) begin
            nb++;
            tick();
        end
        check("busy_cycles_07", nb, FRAME_CYC);
        offer(8'h03, 1'b0, a0);
        valid = 1'b0;
        wait_idle("idle_after_03");

        // default 133 MHz / 12 Mbaud: 0x55 toggles the line at every bit boundary
        k = 0;
        while (!f_ready && k < 20) begin
            tick();
            k++;
        end
        check("fast_ready", f_ready, 1);
        f_data  = 8'h55;
        f_valid = 1'b1;
        tick();
        f_valid = 1'b0;
        fn = cyc;
        check("fast_start_low", f_rxd, 0);
        prev = f_rxd;
        ntr  = 0;
        t[0] = fn;
        k    = 0;
        while (f_busy && k < 300) begin
            tick();
            k++;
            if (f_busy && f_rxd != prev && ntr < 9) begin
                ntr++;
                t[ntr] = cyc;
                prev   = f_rxd;
            end
        end
        fend = cyc;
        check("fast_transitions", ntr, 9);
        for (int j = 0; j < 9; j++) begin
            check_range("fast_bit_len", t[j+1] - t[j], (j == 8) ? 11 * FAST_W : 11, (j == 8) ? 12 * FAST_W : 12);
        end
        check_range("fast_stop_len", fend - t[9], 11, 12);
        check_range("fast_frame_len", fend - fn, FAST_TOTAL - 1, FAST_TOTAL + 1);

        repeat (20) tick();
        check("frames_seen", frames_seen, 8);
        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
